// File: rtl/nf10_nic_probe_injector.sv
// Stream stage that forwards ingress packets with a forced destination-port byte
// and periodically inserts a templated probe packet carrying a sequence number.
module nf10_nic_probe_injector #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24,
  parameter int FIFO_DEPTH_BITS      = 2,
  parameter int PROBE_BEATS          = 2,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic                              cfg_enable,
  input  logic [CNT_WIDTH-1:0]              cfg_interval,
  input  logic [7:0]                        cfg_dst_port,
  input  logic [47:0]                       cfg_dst_mac,
  input  logic [47:0]                       cfg_src_mac,
  input  logic [15:0]                       cfg_ethertype,
  input  logic                              cfg_clr,
  output logic [CNT_WIDTH-1:0]              stat_fwd_pkts,
  output logic [CNT_WIDTH-1:0]              stat_probe_pkts
);

  localparam int DW     = C_S_AXIS_DATA_WIDTH;
  localparam int SW     = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW     = C_S_AXIS_TUSER_WIDTH;
  localparam int FW     = DW + SW + UW + 1;
  localparam int DEPTH  = 1 << FIFO_DEPTH_BITS;
  localparam int BEAT_W = (PROBE_BEATS > 1) ? $clog2(PROBE_BEATS) : 1;
  localparam logic [BEAT_W-1:0]          LAST_BEAT = BEAT_W'(PROBE_BEATS - 1);
  localparam logic [FIFO_DEPTH_BITS:0]   NF_LEVEL  = (FIFO_DEPTH_BITS + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    BOUNDARY = 2'd0,
    PKT      = 2'd1,
    PROBE    = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;

  logic [FW-1:0]              r_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   r_count;
  logic                       r_alive;

  logic [CNT_WIDTH-1:0]       r_since_probe;
  logic [CNT_WIDTH-1:0]       r_seq;
  logic [CNT_WIDTH-1:0]       r_stat_fwd;
  logic [CNT_WIDTH-1:0]       r_stat_probe;
  logic [BEAT_W-1:0]          r_beat;

  logic                       w_wr;
  logic                       w_rd;
  logic                       w_empty;
  logic                       w_nearly_full;
  logic [DW-1:0]              w_head_data;
  logic [SW-1:0]              w_head_strb;
  logic [UW-1:0]              w_head_user;
  logic                       w_head_last;
  logic [UW-1:0]              w_fwd_user;
  logic [UW-1:0]              w_probe_user;
  logic [DW-1:0]              w_probe_hdr;
  logic [CNT_WIDTH-1:0]       w_since_inc;
  logic                       w_inject;
  logic                       w_fwd_eop;
  logic                       w_probe_xfer;
  logic                       w_probe_done;

  // Ingress fallthrough FIFO: the head is visible combinationally.
  assign w_empty       = (r_count == '0);
  assign w_nearly_full = (r_count >= NF_LEVEL);
  assign s_axis_tready = r_alive & ~w_nearly_full;
  assign w_wr          = s_axis_tvalid & s_axis_tready;

  assign {w_head_last, w_head_user, w_head_strb, w_head_data} = r_mem[r_rd_ptr];

  always_ff @(posedge axi_aclk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_alive  <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_fwd_user                      = w_head_user;
    w_fwd_user[DST_PORT_POS +: 8]   = cfg_dst_port;
    w_probe_user                    = '0;
    w_probe_user[DST_PORT_POS +: 8] = cfg_dst_port;
    w_probe_user[SRC_PORT_POS +: 8] = 8'h00;
  end

  always_comb begin
    w_probe_hdr                   = '0;
    w_probe_hdr[47:0]             = cfg_dst_mac;
    w_probe_hdr[95:48]            = cfg_src_mac;
    w_probe_hdr[111:96]           = cfg_ethertype;
    w_probe_hdr[112 +: CNT_WIDTH] = r_seq;
  end

  // The >= compare lets a lowered interval fire at the very next packet end.
  assign w_since_inc = r_since_probe + 1'b1;
  assign w_inject    = cfg_enable && (cfg_interval != '0) && (w_since_inc >= cfg_interval);

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state <= BOUNDARY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_rd          = 1'b0;
    w_fwd_eop     = 1'b0;
    w_probe_xfer  = 1'b0;
    w_probe_done  = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = w_head_data;
    m_axis_tstrb  = w_head_strb;
    m_axis_tuser  = w_fwd_user;
    m_axis_tlast  = w_head_last;
    case (r_state)
      BOUNDARY, PKT: begin
        m_axis_tvalid = ~w_empty;
        if (!w_empty && m_axis_tready) begin
          w_rd = 1'b1;
          if (w_head_last) begin
            w_fwd_eop    = 1'b1;
            w_state_next = w_inject ? PROBE : BOUNDARY;
          end else begin
            w_state_next = PKT;
          end
        end
      end
      PROBE: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = (r_beat == '0) ? w_probe_hdr : '0;
        m_axis_tstrb  = '1;
        m_axis_tuser  = w_probe_user;
        m_axis_tlast  = (r_beat == LAST_BEAT);
        if (m_axis_tready) begin
          w_probe_xfer = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_probe_done = 1'b1;
            w_state_next = BOUNDARY;
          end
        end
      end
      default: w_state_next = BOUNDARY;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_since_probe <= '0;
      r_beat        <= '0;
    end else begin
      if (w_fwd_eop) begin
        r_since_probe <= w_inject ? '0 : w_since_inc;
      end
      if (w_probe_done) begin
        r_beat <= '0;
      end else if (w_probe_xfer) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // A host clear wins over any increment landing in the same cycle.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_seq        <= '0;
      r_stat_fwd   <= '0;
      r_stat_probe <= '0;
    end else if (cfg_clr) begin
      r_seq        <= '0;
      r_stat_fwd   <= '0;
      r_stat_probe <= '0;
    end else begin
      if (w_probe_done) begin
        r_seq        <= r_seq + 1'b1;
        r_stat_probe <= r_stat_probe + 1'b1;
      end
      if (w_fwd_eop) begin
        r_stat_fwd <= r_stat_fwd + 1'b1;
      end
    end
  end

  assign stat_fwd_pkts   = r_stat_fwd;
  assign stat_probe_pkts = r_stat_probe;

endmodule

// File: tb/tb_nf10_nic_probe_injector.sv
// Scoreboard bench for nf10_nic_probe_injector: the stimulus side queues expected
// egress beats (forwarded and probe), a negedge monitor pops and compares them.
module tb_nf10_nic_probe_injector;

  localparam int DW  = 256;
  localparam int SW  = DW / 8;
  localparam int UW  = 128;
  localparam int CW  = 32;
  localparam int PB  = 2;
  localparam int DST = 24;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic [SW-1:0] s_tstrb;
  logic [UW-1:0] s_tuser;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          cfg_enable;
  logic [CW-1:0] cfg_interval;
  logic [7:0]    cfg_dst_port;
  logic [47:0]   cfg_dst_mac;
  logic [47:0]   cfg_src_mac;
  logic [15:0]   cfg_ethertype;
  logic          cfg_clr;
  logic [CW-1:0] stat_fwd;
  logic [CW-1:0] stat_probe;

  nf10_nic_probe_injector #(
    .C_M_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_M_AXIS_TUSER_WIDTH(UW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .SRC_PORT_POS        (16),
    .DST_PORT_POS        (DST),
    .FIFO_DEPTH_BITS     (2),
    .PROBE_BEATS         (PB),
    .CNT_WIDTH           (CW)
  ) dut (
    .axi_aclk       (clk),
    .axi_resetn     (rst_n),
    .s_axis_tdata   (s_tdata),
    .s_axis_tstrb   (s_tstrb),
    .s_axis_tuser   (s_tuser),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .s_axis_tlast   (s_tlast),
    .m_axis_tdata   (m_tdata),
    .m_axis_tstrb   (m_tstrb),
    .m_axis_tuser   (m_tuser),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tlast   (m_tlast),
    .cfg_enable     (cfg_enable),
    .cfg_interval   (cfg_interval),
    .cfg_dst_port   (cfg_dst_port),
    .cfg_dst_mac    (cfg_dst_mac),
    .cfg_src_mac    (cfg_src_mac),
    .cfg_ethertype  (cfg_ethertype),
    .cfg_clr        (cfg_clr),
    .stat_fwd_pkts  (stat_fwd),
    .stat_probe_pkts(stat_probe)
  );

  always #5 clk = ~clk;

  beat_t       sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_beats  = 0;
  int unsigned m_since  = 0;
  int unsigned m_seq    = 0;
  int unsigned m_fwd    = 0;
  int unsigned m_probe  = 0;
  bit          rand_tready = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: one transfer per negedge where valid&ready; stall stability too.
  beat_t r_stalled;
  bit    have_stall = 1'b0;
  always @(negedge clk) begin
    beat_t cur;
    beat_t exp;
    cur = '{data: m_tdata, strb: m_tstrb, user: m_tuser, last: m_tlast};
    if (rst_n) begin
      if (have_stall) begin
        n_checks++;
        if (!m_tvalid || cur !== r_stalled) begin
          n_fail++;
          $display("FAIL stall_hold: output changed while stalled, got %h", cur);
        end
      end
      have_stall = m_tvalid && !m_tready;
      r_stalled  = cur;
      if (m_tvalid && m_tready) begin
        n_checks++;
        n_beats++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL egress_extra: unexpected beat %h", cur);
        end else begin
          exp = sb.pop_front();
          if (cur !== exp) begin
            n_fail++;
            $display("FAIL egress_beat: got %h expected %h", cur, exp);
          end else begin
            $display("egress beat %0d last=%0b user_dst=%h ok", n_beats, cur.last, cur.user[DST +: 8]);
          end
        end
      end
    end else begin
      have_stall = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rand_tready) begin
      #1;
      m_tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic push_probe();
    beat_t b;
    for (int i = 0; i < PB; i++) begin
      b = '0;
      if (i == 0) begin
        b.data[47:0]    = cfg_dst_mac;
        b.data[95:48]   = cfg_src_mac;
        b.data[111:96]  = cfg_ethertype;
        b.data[143:112] = m_seq;
      end
      b.strb           = '1;
      b.user[DST +: 8] = cfg_dst_port;
      b.last           = (i == PB - 1);
      sb.push_back(b);
    end
    m_seq++;
    m_probe++;
  endtask

  task automatic send_pkt(input int nbeats);
    beat_t b;
    int    wait_cnt;
    for (int i = 0; i < nbeats; i++) begin
      for (int w = 0; w < DW / 32; w++) s_tdata[w*32 +: 32] = $urandom;
      for (int w = 0; w < UW / 32; w++) s_tuser[w*32 +: 32] = $urandom;
      s_tstrb  = $urandom;
      s_tlast  = (i == nbeats - 1);
      s_tvalid = 1'b1;
      b = '{data: s_tdata, strb: s_tstrb, user: s_tuser, last: s_tlast};
      b.user[DST +: 8] = cfg_dst_port;
      sb.push_back(b);
      wait_cnt = 0;
      forever begin
        @(negedge clk);
        if (s_tready) begin
          @(posedge clk);
          #1;
          break;
        end
        wait_cnt++;
        if (wait_cnt > 2000) begin
          check("ingress_timeout", 64'(wait_cnt), 64'd0);
          break;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_fwd++;
    if (cfg_enable && cfg_interval != 0 && m_since + 1 >= cfg_interval) begin
      m_since = 0;
      push_probe();
    end else begin
      m_since++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_queue_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic stop_rand();
    rand_tready = 1'b0;
    @(posedge clk);
    #2;
    m_tready = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    s_tdata       = '0;
    s_tstrb       = '0;
    s_tuser       = '0;
    s_tvalid      = 1'b0;
    s_tlast       = 1'b0;
    m_tready      = 1'b1;
    cfg_enable    = 1'b1;
    cfg_interval  = 32'd3;
    cfg_dst_port  = 8'h04;
    cfg_dst_mac   = 48'h0200_1122_3344;
    cfg_src_mac   = 48'h0200_AABB_CCDD;
    cfg_ethertype = 16'h88B5;
    cfg_clr       = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_m_tvalid", 64'(m_tvalid), 64'd0);
    check("reset_s_tready", 64'(s_tready), 64'd0);
    check("reset_stat_fwd", 64'(stat_fwd), 64'd0);
    check("reset_stat_probe", 64'(stat_probe), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Ten 1-beat packets, interval 3.
    for (int p = 0; p < 10; p++) send_pkt(1);
    drain();
    check("p1_stat_fwd", 64'(stat_fwd), 64'd10);
    check("p1_stat_probe", 64'(stat_probe), 64'd3);

    // Back-to-back 5-beat packets under random backpressure, interval 2.
    cfg_interval = 32'd2;
    rand_tready  = 1'b1;
    for (int p = 0; p < 6; p++) send_pkt(5);
    drain();
    stop_rand();
    check("p2_stat_fwd", 64'(stat_fwd), 64'(m_fwd));
    check("p2_stat_probe", 64'(stat_probe), 64'd6);

    // Injection disabled by cfg_enable, then by cfg_interval=0.
    cfg_enable = 1'b0;
    for (int p = 0; p < 10; p++) send_pkt(2);
    drain();
    cfg_enable   = 1'b1;
    cfg_interval = 32'd0;
    for (int p = 0; p < 10; p++) send_pkt(2);
    drain();
    check("p3_stat_fwd", 64'(stat_fwd), 64'd36);
    check("p3_stat_probe", 64'(stat_probe), 64'd6);

    // Ingress backs up during a stalled packet; cfg_clr lands on the probe's last beat.
    cfg_interval = 32'd1;
    m_tready     = 1'b0;
    send_pkt(3);
    repeat (2) @(posedge clk);
    #1;
    check("p4_s_tready_full", 64'(s_tready), 64'd0);
    m_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("p4_pending_beats", 64'(sb.size()), 64'd1);
    m_tready = 1'b1;
    cfg_clr  = 1'b1;
    @(posedge clk);
    #1;
    cfg_clr = 1'b0;
    m_fwd   = 0;
    m_probe = 0;
    m_seq   = 0;
    repeat (2) @(posedge clk);
    #1;
    check("p4_clr_stat_probe", 64'(stat_probe), 64'd0);
    check("p4_clr_stat_fwd", 64'(stat_fwd), 64'd0);
    send_pkt(1);
    drain();
    check("p4_after_stat_probe", 64'(stat_probe), 64'd1);

    // Asynchronous reset in the middle of a probe.
    m_tready = 1'b0;
    send_pkt(1);
    repeat (2) @(posedge clk);
    #1;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("p5_pending_beats", 64'(sb.size()), 64'd1);
    check("p5_midprobe_tvalid", 64'(m_tvalid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("p5_rst_tvalid", 64'(m_tvalid), 64'd0);
    check("p5_rst_s_tready", 64'(s_tready), 64'd0);
    check("p5_rst_stat_fwd", 64'(stat_fwd), 64'd0);
    check("p5_rst_stat_probe", 64'(stat_probe), 64'd0);
    sb.delete();
    m_since = 0;
    m_seq   = 0;
    m_fwd   = 0;
    m_probe = 0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_pkt(2);
    send_pkt(2);
    drain();
    check("p5_after_stat_fwd", 64'(stat_fwd), 64'd2);
    check("p5_after_stat_probe", 64'(stat_probe), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nf10_nic_probe_injector.md
Name: nf10_nic_probe_injector

Overview:
- Stream stage in the NIC datapath, between the RX queues and the output queues, in the same slot as the NIC output-port-lookup stage.
- Forwards every ingress packet unchanged, except that the destination-port byte in tuser is forced to a configured value.
- After every cfg_interval forwarded packets, it inserts a self-generated probe packet of PROBE_BEATS beats, built from a configurable header template and carrying a running sequence number.
- Generalises the earlier fixed two-beat, fixed-count injector: width, FIFO depth, probe length, interval and port are all parameters or config inputs, and injection is periodic rather than one-shot.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master data width; must be a multiple of 64 and at least 256.
- C_S_AXIS_DATA_WIDTH, 256, slave data width; must equal C_M_AXIS_DATA_WIDTH.
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; must equal C_M_AXIS_TUSER_WIDTH.
- SRC_PORT_POS, 16, bit offset of the source-port byte in tuser.
- DST_PORT_POS, 24, bit offset of the destination-port byte in tuser.
- FIFO_DEPTH_BITS, 2, log2 depth of the ingress fallthrough FIFO.
- PROBE_BEATS, 2, beats per probe packet; range 1..16.
- CNT_WIDTH, 32, width of the interval, sequence and statistics counters.

Ports:
- axi_aclk  in  1  clock.
- axi_resetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  ingress data.
- s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  ingress byte strobes.
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  ingress metadata.
- s_axis_tvalid  in  1  ingress valid.
- s_axis_tready  out  1  ingress ready; equals NOT FIFO nearly_full.
- s_axis_tlast  in  1  ingress end of packet.
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  egress data.
- m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  egress byte strobes.
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  egress metadata.
- m_axis_tvalid  out  1  egress valid.
- m_axis_tready  in  1  egress ready.
- m_axis_tlast  out  1  egress end of packet.
- cfg_enable  in  1  injection enable; sampled at packet boundaries only.
- cfg_interval  in  CNT_WIDTH  forwarded packets per probe; 0 disables injection.
- cfg_dst_port  in  8  one-hot port written into tuser[DST_PORT_POS+7:DST_PORT_POS] of every egress packet.
- cfg_dst_mac  in  48  probe destination MAC.
- cfg_src_mac  in  48  probe source MAC.
- cfg_ethertype  in  16  probe ethertype.
- cfg_clr  in  1  synchronous clear of the sequence and statistics counters.
- stat_fwd_pkts  out  CNT_WIDTH  count of forwarded packets.
- stat_probe_pkts  out  CNT_WIDTH  count of injected probes.

Behaviour:
- Reset (async, axi_resetn=0):
  - state=BOUNDARY; FIFO emptied.
  - m_axis_tvalid=0, s_axis_tready=0 while reset is asserted.
  - since_probe=0, seq=0, beat=0, both stat counters 0.
- Reset asserted mid-packet or mid-probe abandons the packet with no completion; downstream tolerates the truncation.
- A beat transfers when tvalid&tready are both 1.
- Forward path:
  - Zero-latency fallthrough from the FIFO head.
  - tdata, tstrb and tlast pass unchanged.
  - tuser passes unchanged except the destination-port byte, which is replaced by cfg_dst_port.
- States:
  - BOUNDARY: output is the FIFO head. On a transferred beat with tlast=0, go to PKT. On a transferred beat with tlast=1, run the end-of-packet check.
  - PKT: output is the FIFO head. On a transferred tlast beat, run the end-of-packet check.
  - PROBE: FIFO read is held off (rd_en=0) and ingress backs up through s_axis_tready.
- End-of-packet check, evaluated on each forwarded packet's last accepted beat:
  - stat_fwd_pkts increments.
  - If cfg_enable=1, cfg_interval!=0 and since_probe+1 >= cfg_interval: since_probe<=0 and next state is PROBE.
  - Otherwise since_probe<=since_probe+1 and next state is BOUNDARY.
- Probe transmission in PROBE:
  - m_axis_tvalid=1 and m_axis_tstrb is all ones on every beat.
  - tuser is zero apart from the destination-port byte (cfg_dst_port) and the source-port byte (0).
  - Beat 0 data: bits[47:0]=cfg_dst_mac, [95:48]=cfg_src_mac, [111:96]=cfg_ethertype, [111+CNT_WIDTH:112]=seq; all remaining bits 0.
  - Beats 1..PROBE_BEATS-1 are all zero.
  - tlast=1 only when beat==PROBE_BEATS-1.
  - beat increments on each transfer.
  - On the last transfer: beat<=0, seq<=seq+1, stat_probe_pkts+1, next state BOUNDARY.
- Flow control:
  - Output holds stable while tvalid=1 and tready=0, in all states.
  - The probe is never interleaved inside a forwarded packet and is never dropped.
- Counter rules:
  - All counters wrap modulo 2^CNT_WIDTH.
  - cfg_clr clears seq and both stat counters; it has priority over a same-cycle increment.
  - cfg_clr does not clear since_probe.
- Configuration changes:
  - Lowering cfg_interval below since_probe triggers a probe at the next packet end (>= compare).
  - Changing cfg_* during PROBE: the MAC and ethertype fields are combinational and take the new values immediately; the host changes them only while cfg_enable=0.
- Simultaneous events: an ingress write in the same cycle as a FIFO read is legal. FIFO full is unreachable because nearly_full gates writes.

Test Plan:
- cfg_interval=3, cfg_enable=1, ten 1-beat packets, tready=1 -> egress shows 3 packets, probe seq=0, 3 packets, probe seq=1, 3 packets, probe seq=2, 1 packet; stat_fwd_pkts=10, stat_probe_pkts=3.
- PROBE_BEATS=4, cfg_interval=1, one 3-beat packet -> 3 data beats, then 4 probe beats with tlast only on the 4th; beat 0 bits[111:96]=cfg_ethertype; s_axis_tready drops once the FIFO fills during the probe.
- Random tready (~50%) with back-to-back 5-beat packets, cfg_interval=2 -> no beat lost or duplicated; outputs stable while stalled; every egress destination-port byte = cfg_dst_port (e.g. 8'h04).
- cfg_interval=0 or cfg_enable=0 over 20 packets -> zero probes, stat_probe_pkts=0; data matches ingress bit for bit apart from the tuser destination-port byte.
- Assert axi_resetn low mid-probe (beat 1 of 2) -> asynchronously, m_axis_tvalid=0 and all counters 0; after release, normal forwarding resumes and the next probe carries seq=0.
- Preload seq to 32'hFFFFFFFF via 2^32-1 probes (or force), then one probe -> probe carries FFFFFFFF, next carries 0; cfg_clr coincident with a probe's last beat -> stat_probe_pkts=0.
